glitch_pulse_gen: RTL and testbench

GLITCH_PULSE_GEN -- requirements
Module: glitch_pulse_gen

---
 rtl/glitch_pulse_gen.sv | 180 ++++++++++++++++++
 tb/tb_glitch_pulse_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_pulse_gen.sv
// Glitch pulse generator: serially programmed offset/width/gap/count,
// fires a burst of glitch pulses on a trigger rising edge.
module glitch_pulse_gen #(
  parameter logic [15:0] DEF_OFFSET = 16'd100,
  parameter logic [15:0] DEF_WIDTH  = 16'd4,
  parameter logic [15:0] DEF_GAP    = 16'd8,
  parameter logic [15:0] DEF_COUNT  = 16'd1
) (
  input  logic sc_clk,
  input  logic sc_reset,
  input  logic trigger,
  input  logic prog_clk,
  input  logic prog_io,
  input  logic prog_reset,
  output logic glitch_out,
  output logic busy,
  output logic done,
  output logic led_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_PULSE, S_GAP, S_DONE, S_LOCK
  } state_t;

  logic [1:0]  r_pclk_s, r_pio_s, r_prst_s;
  logic        r_pclk_d;
  logic [4:0]  r_bitcnt;
  logic [16:0] r_shift;
  logic [15:0] r_offset, r_width, r_gap, r_count;
  logic        w_pedge;
  logic [17:0] w_frame;
  logic [15:0] w_data;

  assign w_pedge = r_pclk_s[1] & ~r_pclk_d;
  assign w_frame = {r_shift, r_pio_s[1]};

  // data arrives LSB first, so the low 16 frame bits are reversed
  always_comb begin
    w_data = '0;
    for (int i = 0; i < 16; i++)
      w_data[i] = w_frame[15-i];
  end

  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      r_pclk_s <= '0;
      r_pio_s  <= '0;
      r_prst_s <= '0;
      r_pclk_d <= 1'b0;
    end else begin
      r_pclk_s <= {r_pclk_s[0], prog_clk};
      r_pio_s  <= {r_pio_s[0], prog_io};
      r_prst_s <= {r_prst_s[0], prog_reset};
      r_pclk_d <= r_pclk_s[1];
    end
  end

  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_offset <= DEF_OFFSET;
      r_width  <= DEF_WIDTH;
      r_gap    <= DEF_GAP;
      r_count  <= DEF_COUNT;
    end else if (!r_prst_s[1]) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (w_pedge && r_bitcnt != 5'd18) begin
      r_shift  <= w_frame[16:0];
      r_bitcnt <= r_bitcnt + 5'd1;
      if (r_bitcnt == 5'd17) begin
        unique case (w_frame[17:16])
          2'd0: r_offset <= w_data;
          2'd1: r_width  <= w_data;
          2'd2: r_gap    <= w_data;
          2'd3: r_count  <= w_data;
        endcase
      end
    end
  end

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt, r_pcnt, w_pcnt;
  logic [15:0] r_sh_w, w_sh_w, r_sh_g, w_sh_g;
  logic        r_trig_d, r_glitch, w_glitch;
  logic        r_busy, r_done;
  logic [15:0] w_wm1, w_gm1;
  logic        w_trig_rise;

  assign w_trig_rise = trigger & ~r_trig_d;
  assign w_wm1 = (r_sh_w == 16'd0) ? 16'd0 : r_sh_w - 16'd1;
  assign w_gm1 = (r_sh_g == 16'd0) ? 16'd0 : r_sh_g - 16'd1;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_pcnt   = r_pcnt;
    w_sh_w   = r_sh_w;
    w_sh_g   = r_sh_g;
    w_glitch = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig_rise) begin
          w_state = S_DELAY;
          w_cnt   = r_offset;
          w_pcnt  = (r_count == 16'd0) ? 16'd1 : r_count;
          w_sh_w  = r_width;
          w_sh_g  = r_gap;
        end
      end
      S_DELAY: begin
        if (r_cnt == 16'd0) begin
          w_state  = S_PULSE;
          w_glitch = 1'b1;
          w_cnt    = w_wm1;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end
      S_PULSE: begin
        w_glitch = 1'b1;
        if (r_cnt != 16'd0) begin
          w_cnt = r_cnt - 16'd1;
        end else if (r_pcnt > 16'd1) begin
          w_state  = S_GAP;
          w_glitch = 1'b0;
          w_cnt    = w_gm1;
          w_pcnt   = r_pcnt - 16'd1;
        end else begin
          w_state  = S_DONE;
          w_glitch = 1'b0;
        end
      end
      S_GAP: begin
        if (r_cnt == 16'd0) begin
          w_state  = S_PULSE;
          w_glitch = 1'b1;
          w_cnt    = w_wm1;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end
      S_DONE: w_state = S_LOCK;
      S_LOCK: if (!trigger) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_sh_w   <= '0;
      r_sh_g   <= '0;
      r_glitch <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      // a trigger already high at release must not count as an edge
      r_trig_d <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_pcnt   <= w_pcnt;
      r_sh_w   <= w_sh_w;
      r_sh_g   <= w_sh_g;
      r_glitch <= w_glitch;
      r_busy   <= (w_state != S_IDLE);
      r_done   <= (w_state == S_DONE);
      r_trig_d <= trigger;
    end
  end

  assign glitch_out = r_glitch;
  assign busy       = r_busy;
  assign done       = r_done;
  assign led_out    = r_busy;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Bench for glitch_pulse_gen: serial programming, pulse trains,
// lockout, mid-sequence writes and asynchronous reset.
module tb_glitch_pulse_gen;

  logic sc_clk = 1'b0;
  logic sc_reset, trigger, prog_clk, prog_io, prog_reset;
  logic glitch_out, busy, done, led_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic g;
    logic d;
  } exp_t;

  exp_t exp_q[$];

  glitch_pulse_gen dut (
    .sc_clk     (sc_clk),
    .sc_reset   (sc_reset),
    .trigger    (trigger),
    .prog_clk   (prog_clk),
    .prog_io    (prog_io),
    .prog_reset (prog_reset),
    .glitch_out (glitch_out),
    .busy       (busy),
    .done       (done),
    .led_out    (led_out)
  );

  always #5 sc_clk = ~sc_clk;

  task automatic tick();
    @(posedge sc_clk);
    #1;
  endtask

  // entry k is the expected {glitch,done} k+1 edges after the detect edge
  task automatic push_pattern(input int off, input int w,
                              input int g, input int c);
    int wn, gn, cn;
    wn = (w == 0) ? 1 : w;
    gn = (g == 0) ? 1 : g;
    cn = (c == 0) ? 1 : c;
    for (int i = 0; i < off; i++) exp_q.push_back('{1'b0, 1'b0});
    for (int p = 0; p < cn; p++) begin
      for (int i = 0; i < wn; i++) exp_q.push_back('{1'b1, 1'b0});
      if (p != cn - 1)
        for (int i = 0; i < gn; i++) exp_q.push_back('{1'b0, 1'b0});
    end
    exp_q.push_back('{1'b0, 1'b1});
    exp_q.push_back('{1'b0, 1'b0});
  endtask

  task automatic prog_write(input logic [1:0] a, input logic [15:0] d,
                            input int nb);
    prog_reset = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < nb; i++) begin
      prog_io = (i < 2) ? a[1-i] : d[i-2];
      repeat (3) tick();
      prog_clk = 1'b1;
      repeat (3) tick();
      prog_clk = 1'b0;
      repeat (3) tick();
    end
    prog_reset = 1'b0;
    prog_io    = 1'b0;
    repeat (4) tick();
  endtask

  task automatic fire();
    trigger = 1'b0;
    repeat (2) tick();
    trigger = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    sc_reset = 1'b0; trigger = 1'b0;
    prog_clk = 1'b0; prog_io = 1'b0; prog_reset = 1'b0;
    #1;
    checks++;
    if ({glitch_out, busy, done, led_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got %b want 0000",
               {glitch_out, busy, done, led_out});
    end
    repeat (3) tick();
    sc_reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_defaults();
    exp_t e;
    fire();
    checks++;
    if (busy !== 1'b1 || led_out !== 1'b1) begin
      errors++;
      $display("FAIL def_busy got %b%b want 11", busy, led_out);
    end
    push_pattern(100, 4, 8, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      checks++;
      if ({glitch_out, done} !== e) begin
        errors++;
        $display("FAIL def_seq got %b%b want %b", glitch_out, done, e);
      end
    end
    trigger = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || led_out !== 1'b0) begin
      errors++;
      $display("FAIL def_idle got %b%b want 00", busy, led_out);
    end
  endtask

  task automatic test_program();
    exp_t e;
    prog_write(2'd0, 16'd0, 18);
    prog_write(2'd1, 16'd2, 18);
    prog_write(2'd2, 16'd3, 18);
    prog_write(2'd3, 16'd3, 18);
    fire();
    push_pattern(0, 2, 3, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      checks++;
      if ({glitch_out, done} !== e) begin
        errors++;
        $display("FAIL prog_seq got %b%b want %b", glitch_out, done, e);
      end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    prog_write(2'd1, 16'd0, 18);
    prog_write(2'd2, 16'd0, 18);
    prog_write(2'd3, 16'd0, 18);
    fire();
    push_pattern(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      checks++;
      if ({glitch_out, done} !== e) begin
        errors++;
        $display("FAIL zero_seq got %b%b want %b", glitch_out, done, e);
      end
    end
  endtask

  task automatic test_lockout();
    exp_t e;
    fire();
    push_pattern(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      checks++;
      if ({glitch_out, done} !== e) begin
        errors++;
        $display("FAIL lock_seq1 got %b%b want %b", glitch_out, done, e);
      end
    end
    repeat (10) begin
      tick();
      checks++;
      if ({glitch_out, done, busy} !== 3'b001) begin
        errors++;
        $display("FAIL lock_hold got %b%b%b want 001",
                 glitch_out, done, busy);
      end
    end
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    push_pattern(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      checks++;
      if ({glitch_out, done} !== e) begin
        errors++;
        $display("FAIL lock_seq2 got %b%b want %b", glitch_out, done, e);
      end
    end
  endtask

  task automatic test_mid_write();
    exp_t e;
    prog_write(2'd0, 16'd300, 18);
    fire();
    push_pattern(300, 0, 0, 0);
    fork
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tick();
        checks++;
        if ({glitch_out, done} !== e) begin
          errors++;
          $display("FAIL mid_old got %b%b want %b", glitch_out, done, e);
        end
      end
      begin
        repeat (5) tick();
        prog_write(2'd0, 16'd5, 18);
      end
    join
    fire();
    push_pattern(5, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      checks++;
      if ({glitch_out, done} !== e) begin
        errors++;
        $display("FAIL mid_new got %b%b want %b", glitch_out, done, e);
      end
    end
    prog_write(2'd0, 16'd7, 17);
    fire();
    push_pattern(5, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      checks++;
      if ({glitch_out, done} !== e) begin
        errors++;
        $display("FAIL short_frame got %b%b want %b", glitch_out, done, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    prog_write(2'd0, 16'd0, 18);
    prog_write(2'd1, 16'd50, 18);
    fire();
    repeat (5) tick();
    checks++;
    if (glitch_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got %b want 1", glitch_out);
    end
    #2 sc_reset = 1'b0;
    #1;
    checks++;
    if ({glitch_out, busy, done, led_out} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async got %b want 0000",
               {glitch_out, busy, done, led_out});
    end
    repeat (2) tick();
    sc_reset = 1'b1;
    repeat (10) begin
      tick();
      checks++;
      if ({glitch_out, busy} !== 2'b00) begin
        errors++;
        $display("FAIL rst_nofire got %b%b want 00", glitch_out, busy);
      end
    end
    fire();
    push_pattern(100, 4, 8, 1);
    fork
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tick();
        checks++;
        if ({glitch_out, done} !== e) begin
          errors++;
          $display("FAIL busy_trig got %b%b want %b", glitch_out, done, e);
        end
      end
      begin
        repeat (10) tick();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
      end
    join
    tick();
    checks++;
    if ({busy, led_out, glitch_out} !== 3'b110) begin
      errors++;
      $display("FAIL rst_lock got %b want 110", {busy, led_out, glitch_out});
    end
    trigger = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_program();
    test_zero();
    test_lockout();
    test_mid_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
